dm_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the datapath's load/store interface.
- Accepts one request at a time from the processor side: address, store data, write enable and the instruction opcode field.
- Inserts a programmable wait, then returns a one-cycle ready pulse.
- Performs MIPS byte, halfword and word lane selection, with sign or zero extension on loads.
- Replaces the single-cycle DM where a stalling memory is modelled.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_lane.sv | 72 +++++++
 rtl/dm_responder.sv | 122 ++++++++++++
 tb/tb_dm_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the dm_responder data-memory model: MIPS load/store
// opcodes, FSM state encoding and wait-counter width.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dm_lane.sv
// Combinational MIPS lane logic: byte/half/word selection with sign or zero
// extension for loads, lane merging for stores, and alignment/opcode checking.
module dm_lane
    import dm_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wr_word,
    output logic [31:0] o_ld_value,
    output logic        o_bad
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_mem_word[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_mem_word[7:0];
            2'd1: w_byte = i_mem_word[15:8];
            2'd2: w_byte = i_mem_word[23:16];
            2'd3: w_byte = i_mem_word[31:24];
            default: w_byte = i_mem_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
    end

    // Stores merge into the current word so untouched lanes keep their contents.
    always_comb begin
        o_wr_word  = i_mem_word;
        o_ld_value = '0;
        o_bad      = 1'b0;
        case (i_op)
            OP_LB:  o_ld_value = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_ld_value = {24'd0, w_byte};
            OP_LH: begin
                o_bad      = i_addr_lo[0];
                o_ld_value = {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                o_bad      = i_addr_lo[0];
                o_ld_value = {16'd0, w_half};
            end
            OP_LW: begin
                o_bad      = |i_addr_lo;
                o_ld_value = i_mem_word;
            end
            OP_SB: begin
                case (i_addr_lo)
                    2'd0: o_wr_word[7:0]   = i_wdata[7:0];
                    2'd1: o_wr_word[15:8]  = i_wdata[7:0];
                    2'd2: o_wr_word[23:16] = i_wdata[7:0];
                    2'd3: o_wr_word[31:24] = i_wdata[7:0];
                    default: o_wr_word = i_mem_word;
                endcase
            end
            OP_SH: begin
                o_bad = i_addr_lo[0];
                if (i_addr_lo[1]) o_wr_word[31:16] = i_wdata[15:0];
                else              o_wr_word[15:0]  = i_wdata[15:0];
            end
            OP_SW: begin
                o_bad     = |i_addr_lo;
                o_wr_word = i_wdata;
            end
            default: o_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with programmable wait and MIPS lane handling.
// Optional access counters rd_cnt/wr_cnt are enabled by defining DM_STATS_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
`ifdef DM_STATS_EN
    output logic        err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`else
    output logic        err
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dm_state_t         r_state;
    dm_state_t         w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [5:0]        r_op;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_mem_word;
    logic [31:0]       w_wr_word;
    logic [31:0]       w_ld_value;
    logic              w_bad;
    logic              w_err;
    logic              w_unused_addr;

    // Upper address bits are deliberately dropped so accesses wrap over the depth.
    assign w_unused_addr = ^addr[31:ADDR_W+2];

    assign w_idx      = r_addr[ADDR_W+1:2];
    assign w_mem_word = r_mem[w_idx];
    assign w_err      = w_bad | (r_we != r_op[3]);

    dm_lane u_lane (
        .i_op       (r_op),
        .i_addr_lo  (r_addr[1:0]),
        .i_mem_word (w_mem_word),
        .i_wdata    (r_wdata),
        .o_wr_word  (w_wr_word),
        .o_ld_value (w_ld_value),
        .o_bad      (w_bad)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == ST_RESP);
        err   = ready & w_err;
        rdata = (ready && !w_err && !r_we) ? w_ld_value : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && req) begin
            r_cnt   <= WAIT_INIT;
            r_we    <= we;
            r_op    <= op;
            r_addr  <= addr[ADDR_W+1:0];
            r_wdata <= wdata;
        end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && r_state == ST_RESP && r_we && !w_err)
            r_mem[w_idx] <= w_wr_word;
    end

`ifdef DM_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (r_state == ST_RESP && !w_err) begin
            if (r_we) wr_cnt <= wr_cnt + 32'd1;
            else      rd_cnt <= rd_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed, table-driven bench for dm_responder (WAIT_CYCLES=2 main instance,
// WAIT_CYCLES=0 instance for back-to-back timing); counters checked under DM_STATS_EN.
module tb_dm_responder;
    import dm_pkg::*;

    typedef struct {
        logic        we;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
        logic        chkData;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req0;
    logic        we;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready, ready0;
    logic [31:0] rdata, rdata0;
    logic        err, err0;
`ifdef DM_STATS_EN
    logic [31:0] rdCnt, wrCnt, rdCnt0, wrCnt0;
`endif

    int checkCount = 0;
    int passCount  = 0;
    vec_t vecs [17];

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .op(op), .addr(addr),
        .wdata(wdata), .ready(ready), .rdata(rdata),
`ifdef DM_STATS_EN
        .err(err), .rd_cnt(rdCnt), .wr_cnt(wrCnt)
`else
        .err(err)
`endif
    );

    dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .op(op), .addr(addr),
        .wdata(wdata), .ready(ready0), .rdata(rdata0),
`ifdef DM_STATS_EN
        .err(err0), .rd_cnt(rdCnt0), .wr_cnt(wrCnt0)
`else
        .err(err0)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issues one request on the main instance and waits (bounded) for ready.
    task automatic applyStimulus(input vec_t v, output logic [31:0] gotData,
                                 output logic gotErr, output int lat);
        we = v.we; op = v.op; addr = v.addr; wdata = v.wdata; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        gotData = rdata;
        gotErr  = err;
        @(posedge clk); #1;
    endtask

    task automatic runVec(input string name, input vec_t v);
        logic [31:0] d;
        logic        e;
        int          lat;
        applyStimulus(v, d, e, lat);
        checkOutput({name, "_lat"}, 32'(lat), 32'd3);
        checkOutput({name, "_err"}, {31'd0, e}, {31'd0, v.expErr});
        if (v.chkData) checkOutput({name, "_rdata"}, d, v.expData);
    endtask

    function automatic vec_t mk(input logic w, input logic [5:0] o, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] ed,
                                input logic ee, input logic cd);
        vec_t v;
        v.we = w; v.op = o; v.addr = a; v.wdata = wd;
        v.expData = ed; v.expErr = ee; v.chkData = cd;
        return v;
    endfunction

    initial begin
        logic sawReady;
        vecs[0]  = mk(1'b1, OP_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        vecs[1]  = mk(1'b0, OP_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        vecs[2]  = mk(1'b1, OP_SW,  32'h20, 32'h80FF7F01, 32'h0,        1'b0, 1'b0);
        vecs[3]  = mk(1'b0, OP_LB,  32'h20, 32'h0,        32'h00000001, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, OP_LB,  32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, OP_LBU, 32'h23, 32'h0,        32'h00000080, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, OP_LH,  32'h22, 32'h0,        32'hFFFF80FF, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, OP_LHU, 32'h22, 32'h0,        32'h000080FF, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, OP_SB,  32'h21, 32'h000000AA, 32'h0,        1'b0, 1'b0);
        vecs[9]  = mk(1'b0, OP_LW,  32'h20, 32'h0,        32'h80FFAA01, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, OP_LW,  32'h22, 32'h0,        32'h0,        1'b1, 1'b1);
        vecs[11] = mk(1'b1, OP_SH,  32'h21, 32'h00001234, 32'h0,        1'b1, 1'b1);
        vecs[12] = mk(1'b0, OP_LW,  32'h20, 32'h0,        32'h80FFAA01, 1'b0, 1'b1);
        vecs[13] = mk(1'b1, OP_LW,  32'h20, 32'h11111111, 32'h0,        1'b1, 1'b1);
        vecs[14] = mk(1'b0, 6'h00,  32'h20, 32'h0,        32'h0,        1'b1, 1'b1);
        vecs[15] = mk(1'b0, OP_LH,  32'h20, 32'h0,        32'hFFFFAA01, 1'b0, 1'b1);
        vecs[16] = mk(1'b0, OP_LW,  32'h20, 32'h0,        32'h80FFAA01, 1'b0, 1'b1);

        reset = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_err",   {31'd0, err}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) runVec($sformatf("vec%0d", i), vecs[i]);
        checkOutput("idle_after_resp", {31'd0, ready}, 32'd0);

        // Zero-wait instance with req held: ready on every other cycle.
        we = 1'b0; op = OP_LW; addr = 32'h0; req0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("held_c%0d", k), {31'd0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0;
        @(posedge clk); #1;

        // Reset during WAIT abandons a pending store.
        runVec("pre40", mk(1'b1, OP_SW, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0));
        we = 1'b1; op = OP_SW; addr = 32'h40; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        sawReady = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) sawReady = 1'b1;
        end
        checkOutput("rst_no_pulse", {31'd0, sawReady}, 32'd0);
        runVec("after_rst", mk(1'b0, OP_LW, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1));
        runVec("alias_sw", mk(1'b1, OP_SW, 32'h40 + (32'd4 << 10), 32'h55AA55AA, 32'h0, 1'b0, 1'b0));
        runVec("alias_lw", mk(1'b0, OP_LW, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, 1'b1));

`ifdef DM_STATS_EN
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("stats_rd_reset", rdCnt, 32'd0);
        checkOutput("stats_wr_reset", wrCnt, 32'd0);
        reset = 1'b1;
        for (int j = 0; j < 3; j++)
            runVec($sformatf("st_ld%0d", j), mk(1'b0, OP_LW, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, 1'b1));
        for (int j = 0; j < 2; j++)
            runVec($sformatf("st_sw%0d", j), mk(1'b1, OP_SW, 32'h44, 32'h0BADF00D, 32'h0, 1'b0, 1'b0));
        runVec("st_mis", mk(1'b0, OP_LW, 32'h42, 32'h0, 32'h0, 1'b1, 1'b1));
        checkOutput("stats_rd", rdCnt, 32'd3);
        checkOutput("stats_wr", wrCnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
